nibble_frame_rx: RTL and testbench
==================================

// Module: nibble_frame_rx
// PURPOSE
//  Serial front end of the 4-input parity path: shifts in one bit per accepted beat, assembles a
//  nibble {a,b,c,d}, then takes one trailing parity bit and checks it against the nibble's XOR parity.
//  The result is presented on a 1-entry valid/ready output register that feeds the downstream parity consumer.
// PARAMETERS
//  EVEN_PAR   1  1: the parity bit makes the total number of 1s across the 5 bits even; 0: makes it odd
//  MSB_FIRST  1  1: the first data bit is a (out_nibble[3]); 0: the first data bit is d (out_nibble[0])
//  CNT_W      8  width of err_cnt (used only with NFR_ERR_CNT_EN)
// PORTS
//  clk          in   1     rising-edge clock
//  areset_n     in   1     asynchronous reset, active low
//  in_valid     in   1     in_bit/in_sof valid this cycle
//  in_ready     out  1     beat accepted when in_valid && in_ready
//  in_bit       in   1     serial data or parity bit
//  in_sof       in   1     beat is data bit 0 of a new frame
//  out_valid    out  1     out_nibble/out_perr hold a frame
//  out_ready    in   1     consumer takes the frame when out_valid && out_ready
//  out_nibble   out  4     {a,b,c,d}
//  out_perr     out  1     1 = parity bit mismatch
//  abort        out  1     1-cycle pulse: partial frame discarded by in_sof
//  err_cnt      out  CNT_W saturating count of frames with out_perr=1 (NFR_ERR_CNT_EN only)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=S_DATA, bit count=0, shift register=0,
//    out_valid=0, out_nibble=0, out_perr=0, abort=0, err_cnt=0.
//  - FSM S_DATA (cnt 0..3): each accepted beat shifts in_bit into position per MSB_FIRST, then cnt++.
//    The beat with cnt=3 moves the FSM to S_PAR.
//  - S_PAR: the accepted beat is the parity bit. Let p = ^nibble. expected = EVEN_PAR ? p : ~p.
//    Then out_perr = (in_bit != expected); load the output register; set out_valid; go to S_DATA with cnt=0.
//  - Latency: parity beat accepted in cycle N -> out_valid=1 in cycle N+1.
//  - in_ready = (state!=S_PAR) || !out_valid || out_ready. Data bits of the next frame are accepted
//    while the output is stalled; only the parity beat back-pressures.
//  - out_nibble and out_perr hold stable while out_valid && !out_ready.
//    Accept and reload in the same cycle: the register takes the new frame and out_valid stays 1.
//  - in_sof on an accepted beat: the beat is data bit 0 (cnt becomes 1, state S_DATA).
//    If the FSM was at cnt!=0 or in S_PAR, the partial frame is discarded and abort pulses the next cycle.
//    in_sof at cnt=0 is legal and does not abort. in_sof is ignored unless the beat is accepted.
//  - in_valid=0: no state change; gaps between bits are allowed anywhere.
//  - The output register is unaffected by an abort.
//  - Async reset mid-frame drops the partial frame and any held output; no abort pulse.
// CONFIGURATION
//  NFR_ERR_CNT_EN defined: err_cnt port present.
//    - Increments by 1 in the cycle the output register loads with out_perr=1.
//    - Saturates at 2^CNT_W-1.
//  NFR_ERR_CNT_EN undefined: err_cnt port and counter absent; all other behaviour is identical.
// STRUCTURE
//  - nibble_frame_pkg:
//      - typedef logic [3:0] nibble_t
//      - enum state_t {S_DATA, S_PAR}
//      - function automatic par4(nibble_t) returning XOR parity
//  - Sub-module nibble_parity4: combinational 4-in parity (dout = a^b^c^d), instantiated once.
// TESTING
//  T1 EVEN_PAR=1, MSB_FIRST=1, bits 1,0,1,1 then par 1, out_ready=1
//     -> next cycle out_valid=1, out_nibble=4'hB, out_perr=0.
//  T2 Same frame with par 0 -> out_perr=1; err_cnt 0->1 (with NFR_ERR_CNT_EN).
//  T3 Frame 4'h0 par 0 with out_ready=0; stream the next frame's 4 data bits
//     -> all accepted, in_ready=0 at its parity beat, out_nibble stays 4'h0.
//     Raise out_ready -> parity accepted the same cycle, next frame appears.
//  T4 Send bits 1,1 then in_sof with bit 0, then 1,1,0 and par 0
//     -> abort pulses once, out_nibble=4'h6, out_perr=0.
//  T5 MSB_FIRST=0, EVEN_PAR=0, bits 1,0,0,0 then par 0 -> out_nibble=4'h1, out_perr=0.
//  T6 Assert areset_n=0 after 2 bits with out_valid=1
//     -> all outputs 0 immediately; after release a full frame 4'h7 par 1 decodes correctly.
//     With NFR_ERR_CNT_EN, CNT_W=2: 5 error frames -> err_cnt=3.

Source files
------------

// File: rtl/nibble_frame_pkg.sv
// Shared types and helpers for the serial nibble/parity receive path.
package nibble_frame_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    S_DATA,
    S_PAR
  } state_t;

  function automatic logic par4(nibble_t n);
    return ^n;
  endfunction

endpackage

// File: rtl/nibble_parity4.sv
// Combinational 4-input XOR parity.
module nibble_parity4 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic dout
);

  assign dout = a ^ b ^ c ^ d;

endmodule

// File: rtl/nibble_frame_rx.sv
// Serial nibble receiver: 4 data beats plus one parity beat into a 1-entry valid/ready register.
// Optional saturating parity-error counter on err_cnt when NFR_ERR_CNT_EN is defined.
module nibble_frame_rx
  import nibble_frame_pkg::*;
#(
  parameter bit          EVEN_PAR  = 1'b1,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_nibble,
  output logic             out_perr,
`ifdef NFR_ERR_CNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic             abort
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("nibble_frame_rx: CNT_W must be at least 1");
  end

  state_t     state_q;
  logic [1:0] cnt_q;
  nibble_t    shift_q;
  logic       out_valid_q;
  nibble_t    out_nibble_q;
  logic       out_perr_q;
  logic       abort_q;

  logic    accept;
  logic    load;
  logic    sof_abort;
  logic    parity;
  logic    par_exp;
  logic    perr_new;
  nibble_t shift_next;
  nibble_t shift_sof;

  nibble_parity4 u_parity (
    .a    (shift_q[3]),
    .b    (shift_q[2]),
    .c    (shift_q[1]),
    .d    (shift_q[0]),
    .dout (parity)
  );

  always_comb begin
    // Only the parity beat can be stalled by a full output register.
    in_ready   = (state_q != S_PAR) || !out_valid_q || out_ready;
    accept     = in_valid && in_ready;
    sof_abort  = accept && in_sof && ((state_q == S_PAR) || (cnt_q != 2'd0));
    load       = accept && !in_sof && (state_q == S_PAR);
    par_exp    = EVEN_PAR ? parity : ~parity;
    perr_new   = (in_bit != par_exp);
    shift_next = MSB_FIRST ? {shift_q[2:0], in_bit} : {in_bit, shift_q[3:1]};
    shift_sof  = MSB_FIRST ? {3'b000, in_bit} : {in_bit, 3'b000};
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= S_DATA;
      cnt_q        <= 2'd0;
      shift_q      <= '0;
      out_valid_q  <= 1'b0;
      out_nibble_q <= '0;
      out_perr_q   <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      abort_q <= sof_abort;
      if (accept) begin
        if (in_sof) begin
          state_q <= S_DATA;
          cnt_q   <= 2'd1;
          shift_q <= shift_sof;
        end else if (state_q == S_PAR) begin
          state_q <= S_DATA;
          cnt_q   <= 2'd0;
        end else begin
          shift_q <= shift_next;
          cnt_q   <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q <= S_PAR;
          end
        end
      end
      // A load in the same cycle as a consume keeps out_valid high.
      if (load) begin
        out_valid_q  <= 1'b1;
        out_nibble_q <= shift_q;
        out_perr_q   <= perr_new;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_nibble = out_nibble_q;
  assign out_perr   = out_perr_q;
  assign abort      = abort_q;

`ifdef NFR_ERR_CNT_EN
  localparam logic [CNT_W-1:0] ErrMax = '1;

  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      err_cnt_q <= '0;
    end else if (load && perr_new && (err_cnt_q != ErrMax)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_nibble_frame_rx.sv
// Bench for nibble_frame_rx: two configurations driven in lock-step, scoreboard on the output side.
module tb_nibble_frame_rx;

  typedef struct packed {
    logic [3:0] nib;
    logic       perr;
  } exp_t;

  typedef struct packed {
    logic [3:0] bits;      // bits[3] is sent first
    logic       par;
    logic [3:0] exp_nib;   // MSB-first interpretation
    logic       exp_perr;  // even parity
  } vec_t;

  localparam int ErrMax = 3;

  logic clk;
  logic areset_n;
  logic in_valid, in_bit, in_sof, out_ready;

  logic       in_ready0, out_valid0, out_perr0, abort0;
  logic [3:0] out_nibble0;
  logic       in_ready1, out_valid1, out_perr1, abort1;
  logic [3:0] out_nibble1;
`ifdef NFR_ERR_CNT_EN
  logic [1:0] err_cnt0, err_cnt1;
`endif

  nibble_frame_rx #(.EVEN_PAR(1'b1), .MSB_FIRST(1'b1), .CNT_W(2)) dut0 (
    .clk        (clk),
    .areset_n   (areset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready0),
    .in_bit     (in_bit),
    .in_sof     (in_sof),
    .out_valid  (out_valid0),
    .out_ready  (out_ready),
    .out_nibble (out_nibble0),
    .out_perr   (out_perr0),
`ifdef NFR_ERR_CNT_EN
    .err_cnt    (err_cnt0),
`endif
    .abort      (abort0)
  );

  nibble_frame_rx #(.EVEN_PAR(1'b0), .MSB_FIRST(1'b0), .CNT_W(2)) dut1 (
    .clk        (clk),
    .areset_n   (areset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready1),
    .in_bit     (in_bit),
    .in_sof     (in_sof),
    .out_valid  (out_valid1),
    .out_ready  (out_ready),
    .out_nibble (out_nibble1),
    .out_perr   (out_perr1),
`ifdef NFR_ERR_CNT_EN
    .err_cnt    (err_cnt1),
`endif
    .abort      (abort1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   ab0 = 0, ab1 = 0;
  int   em0 = 0, em1 = 0;
  bit   rand_rdy = 0;
  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Odd parity, LSB-first view of the same serial stream.
  function automatic exp_t model1(input logic [3:0] bits, input logic par);
    exp_t e;
    e.nib  = {bits[0], bits[1], bits[2], bits[3]};
    e.perr = (par != ~(^e.nib));
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!areset_n) begin
        q0.delete();
        q1.delete();
        em0 = 0;
        em1 = 0;
      end else begin
        if (abort0) ab0++;
        if (abort1) ab1++;
        if (out_valid0 && out_ready) begin
          if (q0.size() == 0) fail_now("dut0_unexpected_out", "output with empty scoreboard");
          else begin
            e = q0.pop_front();
            chk("dut0_nibble", out_nibble0, e.nib);
            chk("dut0_perr", out_perr0, e.perr);
            if (e.perr && em0 < ErrMax) em0++;
`ifdef NFR_ERR_CNT_EN
            chk("dut0_err_cnt", err_cnt0, em0);
`endif
          end
        end
        if (out_valid1 && out_ready) begin
          if (q1.size() == 0) fail_now("dut1_unexpected_out", "output with empty scoreboard");
          else begin
            e = q1.pop_front();
            chk("dut1_nibble", out_nibble1, e.nib);
            chk("dut1_perr", out_perr1, e.perr);
            if (e.perr && em1 < ErrMax) em1++;
`ifdef NFR_ERR_CNT_EN
            chk("dut1_err_cnt", err_cnt1, em1);
`endif
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic b, input logic sof);
    bit acc = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_sof   = sof;
    for (int i = 0; i < 64 && !acc; i++) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready0;
      @(posedge clk);
      #1;
    end
    if (!acc) fail_now("accept_timeout", "actual no accept, required accept within 64 cycles");
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.nib  = v.exp_nib;
    e.perr = v.exp_perr;
    q0.push_back(e);
    q1.push_back(model1(v.bits, v.par));
  endtask

  task automatic send_frame(input vec_t v, input logic sof_first, input bit gaps);
    push_exp(v);
    for (int k = 3; k >= 0; k--) begin
      send_beat(v.bits[k], sof_first && (k == 3));
      if (gaps && $urandom_range(0, 1) == 1) idle(1);
    end
    send_beat(v.par, 1'b0);
  endtask

  task automatic drain(input string name);
    rand_rdy  = 0;
    out_ready = 1'b1;
    idle(4);
    chk({name, "_q0_empty"}, q0.size(), 0);
    chk({name, "_q1_empty"}, q1.size(), 0);
  endtask

  initial begin
    vec_t v;
    int   a0, a1;
    areset_n  = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;

    vecs[0] = '{4'b1011, 1'b1, 4'hB, 1'b0};
    vecs[1] = '{4'b1011, 1'b0, 4'hB, 1'b1};
    vecs[2] = '{4'b0000, 1'b0, 4'h0, 1'b0};
    vecs[3] = '{4'b1111, 1'b0, 4'hF, 1'b0};
    vecs[4] = '{4'b0111, 1'b1, 4'h7, 1'b0};
    vecs[5] = '{4'b1000, 1'b0, 4'h8, 1'b1};
    vecs[6] = '{4'b0101, 1'b1, 4'h5, 1'b1};
    vecs[7] = '{4'b1100, 1'b0, 4'hC, 1'b0};

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_nibble", out_nibble0, 0);
    chk("rst_out_perr", out_perr0, 0);
    chk("rst_abort", abort0, 0);
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid1", out_valid1, 0);
`ifdef NFR_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt0, 0);
`endif
    @(posedge clk);
    #1 areset_n = 1'b1;

    // Pass 0 back-to-back with out_ready high; pass 1 with gaps and random back-pressure.
    for (int p = 0; p < 2; p++) begin
      rand_rdy = (p == 1);
      for (int i = 0; i < 8; i++) send_frame(vecs[i], i[0], p == 1);
      drain("table");
    end
    chk("sof_cnt0_no_abort0", ab0, 0);
    chk("sof_cnt0_no_abort1", ab1, 0);

    // Stalled output: next frame's data flows, its parity beat waits.
    out_ready = 1'b0;
    v = '{4'b0000, 1'b0, 4'h0, 1'b0};
    send_frame(v, 1'b0, 0);
    v = '{4'b1010, 1'b0, 4'hA, 1'b0};
    push_exp(v);
    for (int k = 3; k >= 0; k--) send_beat(v.bits[k], 1'b0);
    in_valid = 1'b1;
    in_bit   = 1'b0;
    @(negedge clk);
    chk("stall_in_ready", in_ready0, 0);
    chk("stall_out_valid", out_valid0, 1);
    chk("stall_out_nibble", out_nibble0, 4'h0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_in_ready", in_ready0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("reload_out_valid", out_valid0, 1);
    chk("reload_out_nibble", out_nibble0, 4'hA);
    @(posedge clk);
    #1;
    drain("stall");

    // Mid-frame in_sof discards the partial frame and pulses abort once.
    a0 = ab0;
    a1 = ab1;
    v  = '{4'b0110, 1'b0, 4'h6, 1'b0};
    push_exp(v);
    send_beat(1'b1, 1'b0);
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b1);
    @(negedge clk);
    chk("abort_pulse0", abort0, 1);
    chk("abort_pulse1", abort1, 1);
    @(posedge clk);
    #1;
    send_beat(1'b1, 1'b0);
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b0);
    drain("abort");
    chk("abort_once0", ab0 - a0, 1);
    chk("abort_once1", ab1 - a1, 1);

    // Async reset with a held output and a partial frame in flight.
    out_ready = 1'b0;
    v = '{4'b0111, 1'b1, 4'h7, 1'b0};
    send_frame(v, 1'b0, 0);
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b0);
    @(negedge clk);
    chk("pre_reset_out_valid", out_valid0, 1);
    @(posedge clk);
    #1 areset_n = 1'b0;
    #1;
    chk("areset_out_valid", out_valid0, 0);
    chk("areset_out_nibble", out_nibble0, 0);
    chk("areset_out_perr", out_perr0, 0);
    chk("areset_abort", abort0, 0);
    chk("areset_out_valid1", out_valid1, 0);
    chk("areset_out_nibble1", out_nibble1, 0);
    @(negedge clk);
    @(posedge clk);
    #1 areset_n = 1'b1;
    out_ready = 1'b1;
    send_frame(v, 1'b0, 0);
    v = '{4'b1011, 1'b0, 4'hB, 1'b1};
    repeat (5) send_frame(v, 1'b0, 0);
    drain("reset");
    chk("reset_no_abort", ab0 - a0, 1);
`ifdef NFR_ERR_CNT_EN
    chk("err_cnt_saturated", err_cnt0, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
